apb_comp_arbiter: RTL and testbench
===================================

# apb_comp_arbiter

Parametrised N-requester to one-completer APB arbiter for the crossbar NoC, instantiated once per completer port. Resolves simultaneous and staggered requests from multiple APB requesters targeting the same completer. Forwards the granted transfer as a compliant SETUP/ACCESS sequence and returns PREADY/PRDATA/PSLVERR to the granted requester only. Generalises the fixed 3-requester contention case to N requesters, configurable widths and selectable arbitration policy.

## Interface
- NUM_REQ, 3: number of requesters (2..8).
- ADDR_W, 60: address width.
- DATA_W, 32: data width.
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- TIMEOUT, 16: ACCESS-cycle limit (used only with the timeout macro; ≥2).

Ports:
- pclk  in  1  clock; all logic on rising edge.
- preset_n  in  1  synchronous active-low reset.
- m_psel  in  NUM_REQ  per-requester select.
- m_pwrite  in  NUM_REQ  per-requester write flag.
- m_paddr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- m_pwdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- m_pready  out  NUM_REQ  one-hot completion to the granted requester.
- m_pslverr  out  NUM_REQ  error flag, valid with m_pready.
- m_prdata  out  DATA_W  shared read data, valid with m_pready.
- s_psel, s_penable, s_pwrite  out  1  completer-side controls.
- s_paddr  out  ADDR_W; s_pwdata  out  DATA_W.
- s_pready, s_pslverr  in  1; s_prdata  in  DATA_W.

## Operation
- FSM: IDLE, SETUP, ACCESS.
- IDLE: if any m_psel high, register grant index and latch that requester's pwrite/paddr/pwdata; go to SETUP. Otherwise stay.
- SETUP: s_psel=1, s_penable=0; unconditionally go to ACCESS.
- ACCESS: s_psel=1, s_penable=1. On s_pready=1:
  - m_pready[grant]=1, m_pslverr[grant]=s_pslverr, m_prdata=s_prdata (combinational).
  - Advance the round-robin pointer to grant+1 mod NUM_REQ.
  - If any m_psel other than grant is high, re-arbitrate and go directly to SETUP. Otherwise go to IDLE.
- Completing requester is excluded from arbitration in its completion cycle.
- Round-robin: first set m_psel at or after the pointer, wrapping. Pointer resets to 0.
- Fixed priority: lowest set index; pointer is ignored.
- No preemption: a granted transfer always completes before re-arbitration.
- s_paddr/s_pwrite/s_pwdata come from latched registers and stay stable from SETUP through ACCESS completion.
- m_pready/m_pslverr to non-granted requesters: always 0.
- Requesters must hold psel and request fields until their m_pready.

## Timing
- Reset (preset_n=0 at a rising edge) forces:
  - state IDLE, pointer 0, latched registers 0.
  - s_psel, s_penable, s_pwrite, s_paddr, s_pwdata = 0.
  - m_pready, m_pslverr, m_prdata = 0.
- Reset mid-SETUP or mid-ACCESS abandons the transfer; no m_pready is issued.
- Minimum latency: m_psel sampled at edge 0; SETUP in cycle 1; ACCESS with m_pready in cycle 2.
- Wait states: each cycle of s_pready=0 extends ACCESS by one cycle.
- Back-to-back: next SETUP immediately follows the completing ACCESS cycle, with no IDLE gap.
- Requests arriving during an active transfer are queued by level only; they are served per policy at the next arbitration.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - A counter clears on SETUP entry and increments each ACCESS cycle with s_pready=0.
  - When it reaches TIMEOUT, the arbiter issues m_pready[grant]=1 and m_pslverr[grant]=1, with m_prdata=0.
  - It then proceeds as a normal completion; s_psel drops if no other request is pending.
  - The completer's late s_pready is ignored.
- APB_ARB_TIMEOUT_EN undefined: no counter is built, and ACCESS waits indefinitely for s_pready.

## Test plan
- Single write (NUM_REQ=3, s_pready=1):
  - Stimulus: requester 1, addr 60'h0AB_CDEF_0123_4567, data 32'hDEADBEEF.
  - Response: s_psel high for cycles 1–2, s_penable only in cycle 2, s_paddr/s_pwdata match; m_pready=3'b010 in cycle 2 only.
- Simultaneous requests:
  - Stimulus: all three m_psel asserted together after reset, ARB_MODE=0.
  - Response: grants in order 0, 1, 2; six consecutive s_psel cycles; no IDLE gaps.
- Staggered requests:
  - Stimulus: requester 2 at edge t, requester 0 at t+1.
  - Response: requester 2 is served first; requester 0's SETUP immediately follows.
  - With ARB_MODE=1 and both requesters asserted at the same edge: requester 0 wins.
- Wait states:
  - Stimulus: s_pready=0 for 3 ACCESS cycles.
  - Response: ACCESS lasts 4 cycles; s_paddr stays stable; other requesters stall.
  - Stimulus: read with s_prdata=32'h12345678, s_pslverr=1.
  - Response: m_prdata=32'h12345678 and m_pslverr[grant]=1 on the completion cycle.
- Timeout:
  - Stimulus: APB_ARB_TIMEOUT_EN defined, TIMEOUT=8, s_pready stuck at 0.
  - Response: m_pready=1 and m_pslverr=1 after the 8th ACCESS cycle; with the macro undefined, no completion after 100 cycles.
- Reset mid-ACCESS:
  - Stimulus: preset_n=0 for 1 cycle during ACCESS.
  - Response: all outputs 0 on the next edge; no m_pready pulse; the next request after reset is granted to requester 0 first.

Source files
------------

// File: rtl/apb_comp_arbiter.sv
// N-requester to one-completer APB arbiter (round-robin or fixed priority).
// Optional ACCESS timeout: define APB_ARB_TIMEOUT_EN.
module apb_comp_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 60,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 16
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic [NUM_REQ-1:0]        m_psel,
  input  logic [NUM_REQ-1:0]        m_pwrite,
  input  logic [NUM_REQ*ADDR_W-1:0] m_paddr,
  input  logic [NUM_REQ*DATA_W-1:0] m_pwdata,
  output logic [NUM_REQ-1:0]        m_pready,
  output logic [NUM_REQ-1:0]        m_pslverr,
  output logic [DATA_W-1:0]         m_prdata,
  output logic                      s_psel,
  output logic                      s_penable,
  output logic                      s_pwrite,
  output logic [ADDR_W-1:0]         s_paddr,
  output logic [DATA_W-1:0]         s_pwdata,
  input  logic                      s_pready,
  input  logic                      s_pslverr,
  input  logic [DATA_W-1:0]         s_prdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   grant_q, grant_d, ptr_q, ptr_next, ptr_arb;
  logic               psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [NUM_REQ-1:0] req_mask;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               done, timeout_hit;

  // Scanning from the highest offset down leaves the nearest match in sel.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] req,
                                            input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] sel;
    int unsigned      idx;
    sel = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      if (ARB_MODE == 1) idx = k - 1;
      else               idx = (32'(ptr) + k - 1) % NUM_REQ;
      if (req[IDX_W'(idx)]) sel = IDX_W'(idx);
    end
    return sel;
  endfunction

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;

  assign timeout_hit = (state_q == ACCESS) && (cnt_q == CNT_W'(TIMEOUT));

  always_ff @(posedge pclk) begin
    if (!preset_n || state_q == SETUP) cnt_q <= '0;
    else if (state_q == ACCESS && !done) cnt_q <= cnt_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    done     = (state_q == ACCESS) && (s_pready || timeout_hit);
    ptr_next = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    req_mask = m_psel;
    ptr_arb  = ptr_q;
    // The completing requester is excluded and the pointer already advanced.
    if (state_q == ACCESS) begin
      req_mask[grant_q] = 1'b0;
      ptr_arb           = ptr_next;
    end
    grant_d   = pick(req_mask, ptr_arb);
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_d == IDX_W'(i)) begin
        sel_write = m_pwrite[i];
        sel_addr  = m_paddr[i*ADDR_W +: ADDR_W];
        sel_wdata = m_pwdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    m_pready  = '0;
    m_pslverr = '0;
    m_prdata  = '0;
    if (done && preset_n) begin
      m_pready[grant_q]  = 1'b1;
      m_pslverr[grant_q] = timeout_hit ? 1'b1 : s_pslverr;
      m_prdata           = timeout_hit ? '0 : s_prdata;
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|m_psel) begin
            state_q  <= SETUP;
            grant_q  <= grant_d;
            pwrite_q <= sel_write;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            psel_q   <= 1'b1;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (done) begin
            ptr_q     <= ptr_next;
            penable_q <= 1'b0;
            if (|req_mask) begin
              state_q  <= SETUP;
              grant_q  <= grant_d;
              pwrite_q <= sel_write;
              addr_q   <= sel_addr;
              wdata_q  <= sel_wdata;
            end else begin
              state_q <= IDLE;
              psel_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_psel    = psel_q;
  assign s_penable = penable_q;
  assign s_pwrite  = pwrite_q;
  assign s_paddr   = addr_q;
  assign s_pwdata  = wdata_q;

endmodule

// File: tb/tb_apb_comp_arbiter.sv
// Self-checking bench for apb_comp_arbiter: transfer-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_apb_comp_arbiter;
  localparam int N   = 3;
  localparam int AW  = 60;
  localparam int DW  = 32;
  localparam int ARB = 0;
  localparam int TMO = 8;

  logic            pclk = 1'b0;
  logic            preset_n;
  logic [N-1:0]    m_psel, m_pwrite, m_pready, m_pslverr;
  logic [AW-1:0]   r_addr [N];
  logic [DW-1:0]   r_data [N];
  logic [N*AW-1:0] m_paddr;
  logic [N*DW-1:0] m_pwdata;
  logic [DW-1:0]   m_prdata, s_pwdata, s_prdata;
  logic            s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
  logic [AW-1:0]   s_paddr;

  always #5 pclk = ~pclk;

  always_comb begin
    m_paddr  = '0;
    m_pwdata = '0;
    for (int i = 0; i < N; i++) begin
      m_paddr[i*AW +: AW]  = r_addr[i];
      m_pwdata[i*DW +: DW] = r_data[i];
    end
  end

  apb_comp_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(ARB), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .m_psel(m_psel), .m_pwrite(m_pwrite), .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata));

  int errors = 0;
  int checks = 0;

  // Reference model: the transfer in flight, if any, and where round-robin resumes.
  bit            mv_busy, mv_acc;
  int            mv_grant, mv_rr, mv_waits;
  logic          mv_write;
  logic [AW-1:0] mv_addr;
  logic [DW-1:0] mv_wdata;

  logic [N-1:0]  last_done, smp_pready, smp_pslverr;
  logic [DW-1:0] smp_prdata;
  logic [AW-1:0] smp_paddr;
  logic [DW-1:0] smp_pwdata;
  logic          smp_psel, smp_penable;
  int            done_order[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int arb(input logic [N-1:0] req, input int from);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (ARB == 1) ? k : (from + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic latch(input int g);
    mv_grant = g;
    mv_write = m_pwrite[g];
    mv_addr  = r_addr[g];
    mv_wdata = r_data[g];
  endtask

  // One clock: compare at negedge with the inputs the next edge will sample,
  // then advance the model on that edge.
  task automatic cycle();
    bit            tmo, fin;
    int            g;
    logic [N-1:0]  ep, ee, others;
    logic [DW-1:0] ed;
    @(negedge pclk);
    tmo = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    tmo = mv_busy && mv_acc && (mv_waits == TMO);
`endif
    fin = preset_n && mv_busy && mv_acc && (s_pready || tmo);
    ep = '0; ee = '0; ed = '0;
    if (fin) begin
      ep[mv_grant] = 1'b1;
      ee[mv_grant] = tmo ? 1'b1 : s_pslverr;
      ed           = tmo ? '0 : s_prdata;
    end
    check("s_psel", s_psel, mv_busy);
    check("s_penable", s_penable, mv_busy && mv_acc);
    check("s_pwrite", s_pwrite, mv_write);
    check("s_paddr", s_paddr, mv_addr);
    check("s_pwdata", s_pwdata, mv_wdata);
    check("m_pready", m_pready, ep);
    check("m_pslverr", m_pslverr, ee);
    check("m_prdata", m_prdata, ed);
    smp_pready = m_pready; smp_pslverr = m_pslverr; smp_prdata = m_prdata;
    smp_psel = s_psel; smp_penable = s_penable; smp_paddr = s_paddr; smp_pwdata = s_pwdata;
    last_done = ep;
    if (fin) done_order.push_back(mv_grant);
    @(posedge pclk);
    if (!preset_n) begin
      mv_busy = 0; mv_acc = 0; mv_rr = 0; mv_waits = 0; mv_grant = 0;
      mv_write = 0; mv_addr = '0; mv_wdata = '0;
    end else if (!mv_busy) begin
      g = arb(m_psel, mv_rr);
      if (g >= 0) begin latch(g); mv_busy = 1; mv_acc = 0; end
    end else if (!mv_acc) begin
      mv_acc = 1; mv_waits = 0;
    end else if (fin) begin
      mv_rr = (mv_grant + 1) % N;
      others = m_psel;
      others[mv_grant] = 1'b0;
      g = arb(others, mv_rr);
      if (g >= 0) begin latch(g); mv_acc = 0; end
      else mv_busy = 0;
    end else begin
      mv_waits++;
    end
    #1;
  endtask

  task automatic drop_done();
    for (int i = 0; i < N; i++) if (last_done[i]) m_psel[i] = 1'b0;
  endtask

  task automatic new_req(input int i);
    m_psel[i]   = 1'b1;
    m_pwrite[i] = 1'($urandom_range(0, 1));
    r_addr[i]   = AW'({$urandom, $urandom});
    r_data[i]   = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int run, ncomp;
    m_psel = '0; m_pwrite = '0; s_pready = 1'b0; s_pslverr = 1'b0; s_prdata = '0;
    for (int i = 0; i < N; i++) begin r_addr[i] = '0; r_data[i] = '0; end
    mv_busy = 0; mv_acc = 0; mv_rr = 0; mv_waits = 0; mv_grant = 0;
    mv_write = 0; mv_addr = '0; mv_wdata = '0; last_done = '0;
    preset_n = 1'b0;
    @(posedge pclk); #1;
    cycle(); cycle();
    check("rst_psel", smp_psel, 1'b0);
    check("rst_paddr", smp_paddr, '0);
    preset_n = 1'b1;

    // Single write from requester 1, zero wait states.
    s_pready = 1'b1;
    r_addr[1] = 60'h0AB_CDEF_0123_4567; r_data[1] = 32'hDEADBEEF;
    m_pwrite[1] = 1'b1; m_psel[1] = 1'b1;
    cycle();
    check("t1_c0_pready", smp_pready, '0);
    cycle();
    check("t1_setup_psel", smp_psel, 1'b1);
    check("t1_setup_penable", smp_penable, 1'b0);
    check("t1_setup_paddr", smp_paddr, 60'h0AB_CDEF_0123_4567);
    check("t1_setup_pwdata", smp_pwdata, 32'hDEADBEEF);
    cycle();
    check("t1_access_penable", smp_penable, 1'b1);
    check("t1_access_pready", smp_pready, 3'b010);
    drop_done();
    cycle();
    check("t1_after_pready", smp_pready, '0);
    check("t1_after_psel", smp_psel, 1'b0);

    // All three requesters together after reset.
    preset_n = 1'b0; cycle(); preset_n = 1'b1;
    for (int i = 0; i < N; i++) new_req(i);
    done_order.delete(); run = 0;
    for (int c = 0; c < 8; c++) begin cycle(); if (smp_psel) run++; drop_done(); end
    check("t2_ngrants", done_order.size(), 3);
    for (int i = 0; i < 3; i++) if (i < done_order.size()) check("t2_order", done_order[i], i);
    check("t2_psel_cycles", run, 6);

    // Staggered: requester 2 one edge before requester 0.
    done_order.delete(); run = 0;
    new_req(2); cycle(); if (smp_psel) run++;
    new_req(0);
    for (int c = 0; c < 5; c++) begin cycle(); if (smp_psel) run++; drop_done(); end
    check("t3_ngrants", done_order.size(), 2);
    if (done_order.size() == 2) begin
      check("t3_first", done_order[0], 2);
      check("t3_second", done_order[1], 0);
    end
    check("t3_psel_cycles", run, 4);

    // Wait states, read with error, requester 1 stalled behind.
    s_pready = 1'b0;
    new_req(0); m_pwrite[0] = 1'b0; cycle();
    new_req(1); cycle();
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("t4_wait_pready", smp_pready, '0);
      check("t4_wait_penable", smp_penable, 1'b1);
      check("t4_wait_paddr", smp_paddr, r_addr[0]);
    end
    s_pready = 1'b1; s_prdata = 32'h12345678; s_pslverr = 1'b1;
    cycle();
    check("t4_done_pready", smp_pready, 3'b001);
    check("t4_done_pslverr", smp_pslverr, 3'b001);
    check("t4_done_prdata", smp_prdata, 32'h12345678);
    drop_done(); s_pslverr = 1'b0;
    for (int c = 0; c < 3; c++) begin cycle(); drop_done(); end

    // Completer never ready.
    s_pready = 1'b0; ncomp = 0;
    new_req(2);
    for (int c = 0; c < 110; c++) begin cycle(); if (|smp_pready) ncomp++; drop_done(); end
`ifdef APB_ARB_TIMEOUT_EN
    check("t5_timeout_completions", ncomp, 1);
`else
    check("t5_stall_completions", ncomp, 0);
`endif
    s_pready = 1'b1;
    for (int c = 0; c < 3; c++) begin cycle(); drop_done(); end

    // Reset during ACCESS with the completer answering in the same cycle.
    s_pready = 1'b0;
    new_req(1); cycle(); cycle();
    new_req(0); new_req(2);
    cycle();
    check("t6_in_access", smp_penable, 1'b1);
    preset_n = 1'b0; s_pready = 1'b1;
    cycle();
    check("t6_rst_no_pready", smp_pready, '0);
    preset_n = 1'b1;
    done_order.delete();
    cycle();
    check("t6_post_psel", smp_psel, 1'b0);
    check("t6_post_paddr", smp_paddr, '0);
    for (int c = 0; c < 9; c++) begin cycle(); drop_done(); end
    check("t6_ngrants", done_order.size(), 3);
    if (done_order.size() > 0) check("t6_first_after_reset", done_order[0], 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_done[i]) begin
          m_psel[i] = 1'b0;
          if ($urandom_range(0, 3) == 0) new_req(i);
        end else if (!m_psel[i] && $urandom_range(0, 3) == 0) begin
          new_req(i);
        end
      end
      s_pready  = ($urandom_range(0, 2) != 0);
      s_pslverr = ($urandom_range(0, 7) == 0);
      s_prdata  = $urandom;
      preset_n  = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
